// File: rtl/control_seq_pkg.sv
// Shared constants for the d16 instruction sequencer: strobe bit positions,
// program-counter operations and sequencer state encodings.
package control_seq_pkg;

  localparam int BIT_FETCH       = 0;
  localparam int BIT_DECODE      = 1;
  localparam int BIT_IMM         = 2;
  localparam int BIT_REG_RD      = 3;
  localparam int BIT_ALU         = 4;
  localparam int BIT_MEM         = 5;
  localparam int BIT_REG_WR      = 6;
  localparam int CONTROL_BIT_MAX = 6;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'b00,
    PC_INC    = 2'b01,
    PC_BRANCH = 2'b10,
    PC_VECTOR = 2'b11
  } pc_op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IMM, S_REG_RD,
    S_ALU, S_MEM, S_REG_WR, S_IRQ, S_HALT
  } state_e;

  // States that talk to memory and therefore stall on mem_wait.
  function automatic logic is_mem_state(state_e s);
    return s inside {S_FETCH, S_IMM, S_MEM};
  endfunction

endpackage

// File: rtl/control_seq_if.sv
// Handshake bundle between the sequencer and the rest of the d16 core.
interface control_seq_if;
  import control_seq_pkg::*;

  logic                       en;
  logic                       en_mem;
  logic                       mem_wait;
  logic                       should_branch;
  logic                       imm;
  logic                       irq;
  logic [CONTROL_BIT_MAX:0]   control_o;
  logic [1:0]                 pc_op;
  logic                       irq_ack;
  logic                       bus_err;
  logic                       halted;

  modport master (
    output en, en_mem, mem_wait, should_branch, imm, irq,
    input  control_o, pc_op, irq_ack, bus_err, halted
  );

  modport slave (
    input  en, en_mem, mem_wait, should_branch, imm, irq,
    output control_o, pc_op, irq_ack, bus_err, halted
  );

endinterface

// File: rtl/control_seq_wait_watchdog.sv
// Counts consecutive memory wait cycles; expire flags the cycle that would
// reach 2^TMO_W-1 waits. Holds while the sequencer is disabled.
module wait_watchdog #(
  parameter int TMO_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic wait_i,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'((1 << TMO_W) - 2);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = wait_i ? cnt_q + TMO_W'(1) : '0;
  end

  assign expire = en && wait_i && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/control_seq.sv
// Multi-cycle d16 instruction sequencer: drives stage strobes and PC ops,
// handles immediate words, memory wait states, bus timeout and IRQ entry.
module control_seq
  import control_seq_pkg::*;
#(
  parameter int IMM_WORDS = 1,
  parameter int TMO_W     = 4,
  parameter int IRQ_EN    = 1
) (
  input logic          clk,
  input logic          rst_n,
  control_seq_if.slave bus
);

  localparam logic [1:0] IMM_LAST = 2'(IMM_WORDS - 1);

  state_e                   state_q, state_d;
  logic [1:0]               imm_cnt_q, imm_cnt_d;
  logic                     bus_err_q, bus_err_d;
  logic                     wd_expire;
  logic [CONTROL_BIT_MAX:0] ctrl;
  pc_op_e                   pc_op;
  logic                     irq_ack;

  wait_watchdog #(.TMO_W(TMO_W)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bus.en),
    .wait_i (is_mem_state(state_q) && bus.mem_wait),
    .expire (wd_expire)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    imm_cnt_d = imm_cnt_q;
    bus_err_d = bus_err_q;
    if (bus.en) begin
      if (wd_expire) begin
        state_d   = S_HALT;
        bus_err_d = 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE:   state_d = S_FETCH;
          S_FETCH:  if (!bus.mem_wait) state_d = S_DECODE;
          S_DECODE: state_d = bus.imm ? S_IMM : S_REG_RD;
          S_IMM: begin
            if (!bus.mem_wait) begin
              if (imm_cnt_q == IMM_LAST) begin
                state_d   = S_REG_RD;
                imm_cnt_d = '0;
              end else begin
                imm_cnt_d = imm_cnt_q + 2'd1;
              end
            end
          end
          S_REG_RD: state_d = S_ALU;
          S_ALU:    state_d = bus.en_mem ? S_MEM : S_REG_WR;
          S_MEM:    if (!bus.mem_wait) state_d = S_REG_WR;
          S_REG_WR: state_d = (IRQ_EN != 0 && bus.irq) ? S_IRQ : S_FETCH;
          S_IRQ:    state_d = S_FETCH;
          S_HALT:   state_d = S_HALT;
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  // Outputs decode the current state; disabling the sequencer silences them.
  always_comb begin
    ctrl    = '0;
    pc_op   = PC_HOLD;
    irq_ack = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        S_FETCH: begin
          ctrl[BIT_FETCH] = 1'b1;
          if (!bus.mem_wait) pc_op = PC_INC;
        end
        S_IMM: begin
          ctrl[BIT_FETCH] = 1'b1;
          ctrl[BIT_IMM]   = 1'b1;
          if (!bus.mem_wait) pc_op = PC_INC;
        end
        S_DECODE: ctrl[BIT_DECODE] = 1'b1;
        S_REG_RD: ctrl[BIT_REG_RD] = 1'b1;
        S_ALU:    ctrl[BIT_ALU]    = 1'b1;
        S_MEM:    ctrl[BIT_MEM]    = 1'b1;
        S_REG_WR: begin
          ctrl[BIT_REG_WR] = 1'b1;
          if (bus.should_branch) pc_op = PC_BRANCH;
        end
        S_IRQ: begin
          pc_op   = PC_VECTOR;
          irq_ack = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      imm_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      imm_cnt_q <= imm_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.control_o = ctrl;
  assign bus.pc_op     = pc_op;
  assign bus.irq_ack   = irq_ack;
  assign bus.bus_err   = bus_err_q;
  assign bus.halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: two instances (IRQ enabled / disabled) share one
// stimulus stream and are each checked against an instruction-plan model.
module tb_control_seq;

  localparam logic [6:0] K_FETCH  = 7'h01;
  localparam logic [6:0] K_DECODE = 7'h02;
  localparam logic [6:0] K_IMM    = 7'h05;
  localparam logic [6:0] K_REG_RD = 7'h08;
  localparam logic [6:0] K_ALU    = 7'h10;
  localparam logic [6:0] K_MEM    = 7'h20;
  localparam logic [6:0] K_REG_WR = 7'h40;
  localparam int         WD_LIMIT = (1 << 4) - 1;

  typedef enum int {M_FETCH, M_DECODE, M_IMM, M_REG_RD, M_ALU, M_MEM, M_REG_WR, M_IRQ} stage_e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_seq_if if0 ();
  control_seq_if if1 ();

  control_seq #(.IMM_WORDS(2), .TMO_W(4), .IRQ_EN(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  control_seq #(.IMM_WORDS(2), .TMO_W(4), .IRQ_EN(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if1.en            = if0.en;
  assign if1.en_mem        = if0.en_mem;
  assign if1.mem_wait      = if0.mem_wait;
  assign if1.should_branch = if0.should_branch;
  assign if1.imm           = if0.imm;
  assign if1.irq           = if0.irq;

  // Model: each instance holds the queue of stages still to run; stages are
  // appended as the instruction reveals them (imm at decode, mem at ALU ...).
  stage_e plan [2][16];
  int     plen [2];
  int     waits [2];
  bit     mhalt [2];
  int     imm_words [2] = '{2, 2};
  bit     irq_en [2]    = '{1'b1, 1'b0};

  int vectors = 0;
  int miscompares = 0;
  bit mw;
  int nw;

  function automatic void push(int m, stage_e s);
    plan[m][plen[m]] = s;
    plen[m]++;
  endfunction

  function automatic void pop(int m);
    for (int i = 1; i < plen[m]; i++) plan[m][i-1] = plan[m][i];
    plen[m]--;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      plen[m] = 0;
      waits[m] = 0;
      mhalt[m] = 1'b0;
    end
  endfunction

  function automatic bit busy(int m);
    return if0.en && !mhalt[m] && plen[m] > 0;
  endfunction

  function automatic logic [6:0] exp_ctrl(int m);
    if (!busy(m)) return '0;
    case (plan[m][0])
      M_FETCH:  return K_FETCH;
      M_DECODE: return K_DECODE;
      M_IMM:    return K_IMM;
      M_REG_RD: return K_REG_RD;
      M_ALU:    return K_ALU;
      M_MEM:    return K_MEM;
      M_REG_WR: return K_REG_WR;
      default:  return '0;
    endcase
  endfunction

  function automatic logic [1:0] exp_pc(int m);
    if (!busy(m)) return 2'b00;
    case (plan[m][0])
      M_FETCH, M_IMM: return if0.mem_wait ? 2'b00 : 2'b01;
      M_REG_WR:       return if0.should_branch ? 2'b10 : 2'b00;
      M_IRQ:          return 2'b11;
      default:        return 2'b00;
    endcase
  endfunction

  function automatic logic exp_ack(int m);
    return busy(m) && plan[m][0] == M_IRQ;
  endfunction

  function automatic void advance(int m);
    stage_e h;
    if (!if0.en || mhalt[m]) return;
    if (plen[m] == 0) begin
      waits[m] = 0;
      push(m, M_FETCH);
      return;
    end
    h = plan[m][0];
    if ((h == M_FETCH || h == M_IMM || h == M_MEM) && if0.mem_wait) begin
      waits[m]++;
      if (waits[m] == WD_LIMIT) begin
        mhalt[m] = 1'b1;
        plen[m] = 0;
      end
      return;
    end
    waits[m] = 0;
    pop(m);
    case (h)
      M_FETCH:  push(m, M_DECODE);
      M_DECODE: begin
        if (if0.imm) for (int i = 0; i < imm_words[m]; i++) push(m, M_IMM);
        push(m, M_REG_RD);
        push(m, M_ALU);
      end
      M_ALU: begin
        if (if0.en_mem) push(m, M_MEM);
        push(m, M_REG_WR);
      end
      M_REG_WR: begin
        if (irq_en[m] && if0.irq) push(m, M_IRQ);
        push(m, M_FETCH);
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("ctrl0",  32'(if0.control_o), 32'(exp_ctrl(0)));
    check("pc0",    32'(if0.pc_op),     32'(exp_pc(0)));
    check("ack0",   32'(if0.irq_ack),   32'(exp_ack(0)));
    check("err0",   32'(if0.bus_err),   32'(mhalt[0]));
    check("halt0",  32'(if0.halted),    32'(mhalt[0]));
    check("ctrl1",  32'(if1.control_o), 32'(exp_ctrl(1)));
    check("pc1",    32'(if1.pc_op),     32'(exp_pc(1)));
    check("ack1",   32'(if1.irq_ack),   32'(exp_ack(1)));
    check("err1",   32'(if1.bus_err),   32'(mhalt[1]));
    check("halt1",  32'(if1.halted),    32'(mhalt[1]));
  endtask

  task automatic step(input bit e, input bit em, input bit mwt, input bit sb, input bit im, input bit iq);
    @(negedge clk);
    if0.en = e;
    if0.en_mem = em;
    if0.mem_wait = mwt;
    if0.should_branch = sb;
    if0.imm = im;
    if0.irq = iq;
    #1 check_outputs();
    @(posedge clk);
    if (rst_n) begin
      advance(0);
      advance(1);
    end
  endtask

  task automatic seek(input stage_e s, input bit em);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!mhalt[0] && plen[0] > 0 && plan[0][0] == s) begin
        found = 1'b1;
        break;
      end
      step(1'b1, em, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL seek: stage %s not reached within budget", s.name());
    end
  endtask

  initial begin
    if0.en = 1'b0;
    if0.en_mem = 1'b0;
    if0.mem_wait = 1'b0;
    if0.should_branch = 1'b0;
    if0.imm = 1'b0;
    if0.irq = 1'b0;
    model_reset();
    #12 check_outputs();
    @(negedge clk) rst_n = 1'b1;

    // Plain instructions, then immediate-carrying ones.
    repeat (12) step(1, 0, 0, 0, 0, 0);
    repeat (10) step(1, 0, 0, 0, 1, 0);

    // Memory stage with three wait cycles.
    seek(M_ALU, 1'b1);
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      mw = (plen[0] > 0 && plan[0][0] == M_MEM && nw < 3);
      if (mw) nw++;
      step(1, 1, mw, 0, 0, 0);
    end

    // Sequencer disabled for four cycles in the middle of MEM.
    seek(M_MEM, 1'b1);
    step(1, 1, 1, 0, 0, 0);
    repeat (4) step(0, 1, 1, 0, 0, 0);
    repeat (8) step(1, 1, 0, 0, 0, 0);

    // Branch and interrupt together at REG_WR.
    seek(M_REG_WR, 1'b0);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    repeat (6) step(1, 0, 0, 0, 0, 0);

    repeat (400)
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);

    // Asynchronous reset in the middle of ALU.
    seek(M_ALU, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    if0.en = 1'b0;
    rst_n = 1'b1;

    // Watchdog boundary: 14 waits recover, 15 waits halt.
    step(1, 0, 0, 0, 0, 0);
    repeat (14) step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    seek(M_FETCH, 1'b0);
    repeat (15) step(1, 0, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 1, 1);

    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
